// File: rtl/key_extract_pkg.sv
// Shared constants for the key extractor: container classes, key width,
// control-header layout, table-type codes, FSM encoding and offset-entry fields.
package key_extract_pkg;

  localparam int W_6B   = 48;
  localparam int W_4B   = 32;
  localparam int W_2B   = 16;
  localparam int META_W = 256;

  localparam int KEY_LEN = 2*W_6B + 2*W_4B + 2*W_2B + 1;

  localparam int HDR_MOD_LSB  = 112;
  localparam int HDR_TYPE_LSB = 124;
  localparam int HDR_IDX_LSB  = 128;

  localparam logic [3:0] TBL_OFFSET = 4'd1;
  localparam logic [3:0] TBL_MASK   = 4'd2;

  localparam logic [1:0] OP_OFF = 2'b00;
  localparam logic [1:0] OP_GT  = 2'b01;
  localparam logic [1:0] OP_GE  = 2'b10;
  localparam logic [1:0] OP_EQ  = 2'b11;

  localparam int CLS_6B = 0;
  localparam int CLS_4B = 1;
  localparam int CLS_2B = 2;

  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 16;
  localparam int CMP_SEL_LSB = IMM_LSB + IMM_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_FORWARD = 2'd3
  } ctl_state_t;

  function automatic int phv_len(input int num_c);
    return (W_6B + W_4B + W_2B) * num_c + META_W;
  endfunction

  // Offset entry, MSB first: {6B s0, 6B s1, 4B s0, 4B s1, 2B s0, 2B s1, opcode, cmp_sel, imm}
  function automatic int opcode_lsb(input int selw);
    return CMP_SEL_LSB + selw;
  endfunction

  function automatic int sel_lsb(input int selw, input int cls, input int which);
    return opcode_lsb(selw) + 2 + selw * (2 * (2 - cls) + (1 - which));
  endfunction

  function automatic int off_entry_w(input int selw);
    return opcode_lsb(selw) + 2 + 6 * selw;
  endfunction

endpackage

// File: rtl/key_ex_cmp.sv
// Unsigned comparison of a selected 2-byte container against an immediate.
module key_ex_cmp
  import key_extract_pkg::*;
(
  input  logic [W_2B-1:0]  operand,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       opcode,
  output logic             result
);

  always_comb begin
    result = 1'b0;
    case (opcode)
      OP_GT:   result = (operand >  imm);
      OP_GE:   result = (operand >= imm);
      OP_EQ:   result = (operand == imm);
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/key_extract_param.sv
// Match-key extractor: two-stage PHV pipeline driven by offset/mask tables
// that are programmed in-band over the control stream.
module key_extract_param
  import key_extract_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STAGE_ID             = 0,
  parameter int KEY_EX_ID            = 1,
  parameter int NUM_C                = 8,
  parameter int ENTRY_NUM            = 16,
  parameter int IDX_LSB              = 129
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [phv_len(NUM_C)-1:0]           phv_in,
  input  logic                                phv_valid_in,
  output logic [phv_len(NUM_C)-1:0]           phv_out,
  output logic                                phv_valid_out,
  output logic [KEY_LEN-1:0]                  key_out,
  output logic [KEY_LEN-1:0]                  key_mask_out,
  output logic                                key_valid_out,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_s_axis_tkeep,
  input  logic                                c_s_axis_tvalid,
  input  logic                                c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_m_axis_tkeep,
  output logic                                c_m_axis_tvalid,
  output logic                                c_m_axis_tlast,
  output ctl_state_t                          ctrl_state
);

  // Handshake: no backpressure anywhere; a PHV or control beat is consumed
  // in every cycle its valid is high, and outputs hold while valid is low.

  localparam int PHV_LEN = phv_len(NUM_C);
  localparam int SELW    = $clog2(NUM_C);
  localparam int IDXW    = $clog2(ENTRY_NUM);
  localparam int ENTRY_W = off_entry_w(SELW);
  localparam int B2_LSB  = META_W;
  localparam int B4_LSB  = B2_LSB + W_2B * NUM_C;
  localparam int B6_LSB  = B4_LSB + W_4B * NUM_C;
  localparam logic [7:0] MOD_ID = {3'(KEY_EX_ID), 5'(STAGE_ID)};

  logic [ENTRY_W-1:0] off_tbl  [ENTRY_NUM];
  logic [KEY_LEN-1:0] mask_tbl [ENTRY_NUM];

  // ---------------- lookup pipeline ----------------
  logic [IDXW-1:0]    lookup_idx;
  logic               s1_valid;
  logic [PHV_LEN-1:0] s1_phv;
  logic [ENTRY_W-1:0] s1_entry;
  logic [KEY_LEN-1:0] s1_mask;

  assign lookup_idx = phv_in[IDX_LSB +: IDXW];

  // Tables are read before this edge's write lands, so a colliding lookup sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_phv   <= '0;
      s1_entry <= '0;
      s1_mask  <= '0;
    end else begin
      s1_valid <= phv_valid_in;
      if (phv_valid_in) begin
        s1_phv   <= phv_in;
        s1_entry <= off_tbl[lookup_idx];
        s1_mask  <= mask_tbl[lookup_idx];
      end
    end
  end

  logic [W_6B-1:0] c6 [NUM_C];
  logic [W_4B-1:0] c4 [NUM_C];
  logic [W_2B-1:0] c2 [NUM_C];

  for (genvar i = 0; i < NUM_C; i++) begin : g_cont
    assign c6[i] = s1_phv[B6_LSB + i*W_6B +: W_6B];
    assign c4[i] = s1_phv[B4_LSB + i*W_4B +: W_4B];
    assign c2[i] = s1_phv[B2_LSB + i*W_2B +: W_2B];
  end

  logic [SELW-1:0]  sel6_0, sel6_1, sel4_0, sel4_1, sel2_0, sel2_1, cmp_sel;
  logic [1:0]       cmp_op;
  logic [IMM_W-1:0] cmp_imm;
  logic             cmp_bit;
  logic [KEY_LEN-1:0] key_nxt;

  assign sel6_0  = s1_entry[sel_lsb(SELW, CLS_6B, 0) +: SELW];
  assign sel6_1  = s1_entry[sel_lsb(SELW, CLS_6B, 1) +: SELW];
  assign sel4_0  = s1_entry[sel_lsb(SELW, CLS_4B, 0) +: SELW];
  assign sel4_1  = s1_entry[sel_lsb(SELW, CLS_4B, 1) +: SELW];
  assign sel2_0  = s1_entry[sel_lsb(SELW, CLS_2B, 0) +: SELW];
  assign sel2_1  = s1_entry[sel_lsb(SELW, CLS_2B, 1) +: SELW];
  assign cmp_op  = s1_entry[opcode_lsb(SELW) +: 2];
  assign cmp_sel = s1_entry[CMP_SEL_LSB +: SELW];
  assign cmp_imm = s1_entry[IMM_LSB +: IMM_W];

  key_ex_cmp u_cmp (
    .operand (c2[cmp_sel]),
    .imm     (cmp_imm),
    .opcode  (cmp_op),
    .result  (cmp_bit)
  );

  assign key_nxt = {c6[sel6_0], c6[sel6_1], c4[sel4_0], c4[sel4_1],
                    c2[sel2_0], c2[sel2_1], cmp_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phv_valid_out <= 1'b0;
      key_valid_out <= 1'b0;
      phv_out       <= '0;
      key_out       <= '0;
      key_mask_out  <= '0;
    end else begin
      phv_valid_out <= s1_valid;
      key_valid_out <= s1_valid;
      if (s1_valid) begin
        phv_out      <= s1_phv;
        key_out      <= key_nxt;
        key_mask_out <= s1_mask;
      end
    end
  end

  // ---------------- control stream ----------------
  ctl_state_t      state, state_nxt;
  logic [3:0]      hdr_type;
  logic            hdr_match, hdr_write;
  logic            wr_is_mask;
  logic [IDXW-1:0] wr_idx;
  logic            fwd, off_we, mask_we;

  assign hdr_type   = c_s_axis_tdata[HDR_TYPE_LSB +: 4];
  assign hdr_match  = (c_s_axis_tdata[HDR_MOD_LSB +: 8] == MOD_ID);
  assign hdr_write  = hdr_match && ((hdr_type == TBL_OFFSET) || (hdr_type == TBL_MASK));
  assign ctrl_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A single-beat packet (header with tlast) always ends back in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (c_s_axis_tvalid && !c_s_axis_tlast) begin
          if (!hdr_match)     state_nxt = ST_FORWARD;
          else if (hdr_write) state_nxt = ST_WRITE;
          else                state_nxt = ST_FLUSH;
        end
      end
      ST_WRITE: begin
        if (c_s_axis_tvalid) state_nxt = c_s_axis_tlast ? ST_IDLE : ST_FLUSH;
      end
      ST_FLUSH, ST_FORWARD: begin
        if (c_s_axis_tvalid && c_s_axis_tlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fwd     = 1'b0;
    off_we  = 1'b0;
    mask_we = 1'b0;
    case (state)
      ST_IDLE:    fwd = c_s_axis_tvalid && !hdr_match;
      ST_FORWARD: fwd = c_s_axis_tvalid;
      ST_WRITE: begin
        off_we  = c_s_axis_tvalid && !wr_is_mask;
        mask_we = c_s_axis_tvalid &&  wr_is_mask;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_is_mask <= 1'b0;
      wr_idx     <= '0;
    end else if (state == ST_IDLE && c_s_axis_tvalid && hdr_write) begin
      wr_is_mask <= (hdr_type == TBL_MASK);
      wr_idx     <= c_s_axis_tdata[HDR_IDX_LSB +: IDXW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        off_tbl[i]  <= '0;
        mask_tbl[i] <= '0;
      end
    end else begin
      if (off_we)  off_tbl[wr_idx]  <= c_s_axis_tdata[ENTRY_W-1:0];
      if (mask_we) mask_tbl[wr_idx] <= c_s_axis_tdata[KEY_LEN-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tlast  <= 1'b0;
    end else begin
      c_m_axis_tvalid <= fwd;
      if (fwd) begin
        c_m_axis_tdata <= c_s_axis_tdata;
        c_m_axis_tuser <= c_s_axis_tuser;
        c_m_axis_tkeep <= c_s_axis_tkeep;
        c_m_axis_tlast <= c_s_axis_tlast;
      end
    end
  end

endmodule

// File: tb/tb_key_extract_param.sv
// Bench for key_extract_param: directed scenarios plus randomized PHV/control
// traffic, checked by a queue-based scoreboard fed from a reference model.
`timescale 1ns/1ps
module tb_key_extract_param;
  import key_extract_pkg::*;

  localparam int DW        = 256;
  localparam int UW        = 128;
  localparam int NUM_C     = 8;
  localparam int ENTRY_NUM = 16;
  localparam int IDX_LSB   = 129;
  localparam int IDXW      = 4;
  localparam int PHV_LEN   = (48 + 32 + 16) * NUM_C + 256;
  localparam int B2        = 256;
  localparam int B4        = B2 + 16 * NUM_C;
  localparam int B6        = B4 + 32 * NUM_C;
  localparam int CW        = DW + UW + DW/8 + 1;
  localparam int EW        = PHV_LEN + 2 * KEY_LEN;
  localparam logic [7:0] MOD_ID = 8'h20;

  typedef struct {
    int s6_0, s6_1, s4_0, s4_1, s2_0, s2_1, op, cs;
    logic [15:0] imm;
  } ent_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk, rst;
  logic [PHV_LEN-1:0] phv_in, phv_out;
  logic phv_valid_in, phv_valid_out, key_valid_out;
  logic [KEY_LEN-1:0] key_out, key_mask_out;
  logic [DW-1:0] c_s_axis_tdata, c_m_axis_tdata;
  logic [UW-1:0] c_s_axis_tuser, c_m_axis_tuser;
  logic [DW/8-1:0] c_s_axis_tkeep, c_m_axis_tkeep;
  logic c_s_axis_tvalid, c_s_axis_tlast, c_m_axis_tvalid, c_m_axis_tlast;
  ctl_state_t ctrl_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  key_extract_param dut (
    .clk(clk), .rst(rst),
    .phv_in(phv_in), .phv_valid_in(phv_valid_in),
    .phv_out(phv_out), .phv_valid_out(phv_valid_out),
    .key_out(key_out), .key_mask_out(key_mask_out), .key_valid_out(key_valid_out),
    .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tuser(c_s_axis_tuser),
    .c_s_axis_tkeep(c_s_axis_tkeep), .c_s_axis_tvalid(c_s_axis_tvalid),
    .c_s_axis_tlast(c_s_axis_tlast),
    .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser),
    .c_m_axis_tkeep(c_m_axis_tkeep), .c_m_axis_tvalid(c_m_axis_tvalid),
    .c_m_axis_tlast(c_m_axis_tlast),
    .ctrl_state(ctrl_state)
  );

  // ---------------- scoreboard state and reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] ctl_q[$];
  ent_t off_m [ENTRY_NUM];
  logic [KEY_LEN-1:0] mask_m [ENTRY_NUM];
  int pk_state = 0;           // 0 header next, 1 table data next, 2 discarding, 3 forwarding
  logic wr_mask;
  logic [IDXW-1:0] wr_idx;
  logic [PHV_LEN-1:0] last_phv;
  logic [KEY_LEN-1:0] last_key, last_mask;
  logic [DW-1:0] pd_q[$];
  logic          pl_q[$];

  function automatic void note(input bit ok, input string msg);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s", msg);
    end
  endfunction

  function automatic void clear_model();
    ent_t z;
    z = '{0, 0, 0, 0, 0, 0, 0, 0, 16'h0};
    for (int i = 0; i < ENTRY_NUM; i++) begin
      off_m[i]  = z;
      mask_m[i] = '0;
    end
    pk_state  = 0;
    wr_mask   = 1'b0;
    wr_idx    = '0;
    last_phv  = '0;
    last_key  = '0;
    last_mask = '0;
    exp_q.delete();
    ctl_q.delete();
  endfunction

  function automatic ent_t unpack_ent(input logic [DW-1:0] d);
    ent_t e;
    e.imm  = d[15:0];
    e.cs   = int'(d[18:16]);
    e.op   = int'(d[20:19]);
    e.s2_1 = int'(d[23:21]);
    e.s2_0 = int'(d[26:24]);
    e.s4_1 = int'(d[29:27]);
    e.s4_0 = int'(d[32:30]);
    e.s6_1 = int'(d[35:33]);
    e.s6_0 = int'(d[38:36]);
    return e;
  endfunction

  function automatic logic [KEY_LEN-1:0] model_key(input logic [PHV_LEN-1:0] p, input ent_t e);
    logic [15:0] c;
    logic cmp;
    c = 16'(p >> (B2 + 16 * e.cs));
    case (e.op)
      1:       cmp = (c >  e.imm);
      2:       cmp = (c >= e.imm);
      3:       cmp = (c == e.imm);
      default: cmp = 1'b0;
    endcase
    return {48'(p >> (B6 + 48 * e.s6_0)), 48'(p >> (B6 + 48 * e.s6_1)),
            32'(p >> (B4 + 32 * e.s4_0)), 32'(p >> (B4 + 32 * e.s4_1)),
            16'(p >> (B2 + 16 * e.s2_0)), 16'(p >> (B2 + 16 * e.s2_1)), cmp};
  endfunction

  function automatic logic [PHV_LEN-1:0] rand_phv(input int idx);
    logic [PHV_LEN-1:0] p;
    for (int i = 0; i < PHV_LEN / 32; i++) p[i*32 +: 32] = $urandom;
    p[IDX_LSB +: IDXW] = 4'(idx);
    return p;
  endfunction

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic string phv_msg(input logic [PHV_LEN-1:0] a, input logic [PHV_LEN-1:0] e);
    for (int i = 0; i < PHV_LEN / 64; i++)
      if (a[i*64 +: 64] !== e[i*64 +: 64])
        return $sformatf("phv_out word%0d act=%h exp=%h", i, a[i*64 +: 64], e[i*64 +: 64]);
    return "phv_out";
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic pv, input logic [PHV_LEN-1:0] p,
                       input logic cv, input logic [DW-1:0] d, input logic cl);
    logic [UW-1:0] u;
    logic [DW/8-1:0] k;
    logic [IDXW-1:0] idx;
    @(posedge clk);
    #1;
    u = {$urandom, $urandom, $urandom, $urandom};
    k = $urandom;
    phv_valid_in    = pv;
    phv_in          = p;
    c_s_axis_tvalid = cv;
    c_s_axis_tdata  = d;
    c_s_axis_tuser  = u;
    c_s_axis_tkeep  = k;
    c_s_axis_tlast  = cl;
    // The lookup model reads the tables before this cycle's control write updates them.
    if (pv) begin
      idx = p[IDX_LSB +: IDXW];
      exp_q.push_back({p, model_key(p, off_m[idx]), mask_m[idx]});
    end
    if (cv) begin
      case (pk_state)
        0: begin
          if (d[119:112] != MOD_ID) begin
            ctl_q.push_back({d, u, k, cl});
            if (!cl) pk_state = 3;
          end else if (d[127:124] == 4'd1 || d[127:124] == 4'd2) begin
            if (!cl) begin
              pk_state = 1;
              wr_mask  = (d[127:124] == 4'd2);
              wr_idx   = d[128 +: IDXW];
            end
          end else if (!cl) pk_state = 2;
        end
        1: begin
          if (wr_mask) mask_m[wr_idx] = d[KEY_LEN-1:0];
          else         off_m[wr_idx]  = unpack_ent(d);
          pk_state = cl ? 0 : 2;
        end
        2: if (cl) pk_state = 0;
        default: begin
          ctl_q.push_back({d, u, k, cl});
          if (cl) pk_state = 0;
        end
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [DW-1:0] header(input logic [7:0] id, input logic [3:0] typ, input int idx);
    logic [DW-1:0] h;
    h = rand_dw();
    h[119:112] = id;
    h[127:124] = typ;
    h[135:128] = {4'($urandom_range(0, 15)), 4'(idx)};
    return h;
  endfunction

  // Queue one control packet of the given kind into the pending-beat list.
  task automatic make_packet(input int kind);
    logic [DW-1:0] d;
    logic [7:0] id;
    int n;
    case (kind)
      0, 1: begin
        pd_q.push_back(header(MOD_ID, (kind == 0) ? 4'd1 : 4'd2, $urandom_range(0, ENTRY_NUM-1)));
        pl_q.push_back(1'b0);
        n = $urandom_range(0, 2);
        pd_q.push_back(rand_dw());
        pl_q.push_back(n == 0);
        for (int i = 0; i < n; i++) begin
          pd_q.push_back(rand_dw());
          pl_q.push_back(i == n - 1);
        end
      end
      2: begin
        do id = 8'($urandom_range(0, 255)); while (id == MOD_ID);
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) begin
          d = (i == 0) ? header(id, 4'($urandom_range(0, 15)), 0) : rand_dw();
          pd_q.push_back(d);
          pl_q.push_back(i == n - 1);
        end
      end
      3: begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
          d = (i == 0) ? header(MOD_ID, 4'($urandom_range(3, 15)), 0) : rand_dw();
          pd_q.push_back(d);
          pl_q.push_back(i == n - 1);
        end
      end
      default: begin
        pd_q.push_back(header(MOD_ID, 4'($urandom_range(1, 2)), $urandom_range(0, ENTRY_NUM-1)));
        pl_q.push_back(1'b1);
      end
    endcase
  endtask

  task automatic run_pending();
    while (pd_q.size() > 0) cycle(1'b0, '0, 1'b1, pd_q.pop_front(), pl_q.pop_front());
  endtask

  task automatic check_reset_outputs(input string tag);
    note(phv_valid_out === 1'b0, $sformatf("%s phv_valid_out act=%b exp=0", tag, phv_valid_out));
    note(key_valid_out === 1'b0, $sformatf("%s key_valid_out act=%b exp=0", tag, key_valid_out));
    note(c_m_axis_tvalid === 1'b0, $sformatf("%s c_m_axis_tvalid act=%b exp=0", tag, c_m_axis_tvalid));
    note(key_out === '0, $sformatf("%s key_out act=%h exp=0", tag, key_out));
    note(key_mask_out === '0, $sformatf("%s key_mask_out act=%h exp=0", tag, key_mask_out));
    note(phv_out === '0, $sformatf("%s phv_out not zero", tag));
    note(c_m_axis_tdata === '0, $sformatf("%s c_m_axis_tdata act=%h exp=0", tag, c_m_axis_tdata));
    note(ctrl_state === ST_IDLE, $sformatf("%s ctrl_state act=%0d exp=%0d", tag, ctrl_state, ST_IDLE));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [CW-1:0] c;
    if (!rst) begin
      note(phv_valid_out === key_valid_out,
           $sformatf("valid_align phv_valid_out=%b key_valid_out=%b", phv_valid_out, key_valid_out));
      if (phv_valid_out === 1'b1) begin
        note(exp_q.size() > 0, "phv_valid_out with empty expected queue");
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          note(phv_out === e[EW-1 -: PHV_LEN], phv_msg(phv_out, e[EW-1 -: PHV_LEN]));
          note(key_out === e[2*KEY_LEN-1 -: KEY_LEN],
               $sformatf("key_out act=%h exp=%h", key_out, e[2*KEY_LEN-1 -: KEY_LEN]));
          note(key_mask_out === e[KEY_LEN-1:0],
               $sformatf("key_mask_out act=%h exp=%h", key_mask_out, e[KEY_LEN-1:0]));
          last_phv  = e[EW-1 -: PHV_LEN];
          last_key  = e[2*KEY_LEN-1 -: KEY_LEN];
          last_mask = e[KEY_LEN-1:0];
        end
      end else begin
        note(key_out === last_key && key_mask_out === last_mask && phv_out === last_phv,
             $sformatf("hold key_out act=%h exp=%h", key_out, last_key));
      end
      if (c_m_axis_tvalid === 1'b1) begin
        note(ctl_q.size() > 0, "c_m_axis_tvalid with empty expected queue");
        if (ctl_q.size() > 0) begin
          c = ctl_q.pop_front();
          note({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast} === c,
               $sformatf("c_m_axis beat act=%h exp=%h",
                         {c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tlast}, c));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [PHV_LEN-1:0] p;
    logic [DW-1:0] d;
    logic pv, cv, cl;

    rst = 1'b1;
    phv_valid_in = 1'b0; phv_in = '0;
    c_s_axis_tvalid = 1'b0; c_s_axis_tdata = '0; c_s_axis_tuser = '0;
    c_s_axis_tkeep = '0; c_s_axis_tlast = 1'b0;
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Fresh tables: index 0 with zeroed container 0 in each class yields a zero key.
    p = rand_phv(0);
    p[B6 +: 48] = '0;
    p[B4 +: 32] = '0;
    p[B2 +: 16] = '0;
    cycle(1'b1, p, 1'b0, '0, 1'b0);
    idle(3);

    // Offset entry 3: sels 7/6 per class, opcode GT, cmp on 2B c7, imm 16'h1000.
    d = rand_dw();
    d[38:0] = {3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 2'b01, 3'd7, 16'h1000};
    cycle(1'b0, '0, 1'b1, header(MOD_ID, 4'd1, 3), 1'b0);
    cycle(1'b0, '0, 1'b1, d, 1'b1);
    p = rand_phv(3);
    p[B6 + 48*7 +: 48] = 48'hffffffffffff;
    p[B6 + 48*6 +: 48] = 48'heeeeeeeeeeee;
    p[B4 + 32*7 +: 32] = 32'hcccccccc;
    p[B4 + 32*6 +: 32] = 32'hbbbbbbbb;
    p[B2 + 16*7 +: 16] = 16'hffff;
    p[B2 + 16*6 +: 16] = 16'heeee;
    cycle(1'b1, p, 1'b0, '0, 1'b0);

    // Mask entry 3 all-ones, then lookups at 3 and 2.
    d = '1;
    cycle(1'b0, '0, 1'b1, header(MOD_ID, 4'd2, 3), 1'b0);
    cycle(1'b0, '0, 1'b1, d, 1'b1);
    cycle(1'b1, rand_phv(3), 1'b0, '0, 1'b0);
    cycle(1'b1, rand_phv(2), 1'b0, '0, 1'b0);

    // Non-matching 3-beat packet passes through; tables stay as they were.
    cycle(1'b0, '0, 1'b1, header(8'h02, 4'd1, 3), 1'b0);
    cycle(1'b0, '0, 1'b1, rand_dw(), 1'b0);
    cycle(1'b0, '0, 1'b1, rand_dw(), 1'b1);
    cycle(1'b1, rand_phv(3), 1'b0, '0, 1'b0);

    // Write to entry 3 colliding with a lookup of entry 3, then a follow-up lookup.
    d = rand_dw();
    d[38:0] = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 2'b11, 3'd2, 16'h00aa};
    cycle(1'b0, '0, 1'b1, header(MOD_ID, 4'd1, 3), 1'b0);
    cycle(1'b1, rand_phv(3), 1'b1, d, 1'b1);
    cycle(1'b1, rand_phv(3), 1'b0, '0, 1'b0);

    // Header-only packet and a flush packet must not write anything.
    cycle(1'b0, '0, 1'b1, header(MOD_ID, 4'd1, 3), 1'b1);
    cycle(1'b0, '0, 1'b1, header(MOD_ID, 4'd7, 3), 1'b0);
    cycle(1'b0, '0, 1'b1, '1, 1'b1);
    cycle(1'b1, rand_phv(3), 1'b0, '0, 1'b0);
    idle(4);

    // Asynchronous reset while the FSM waits for table data.
    cycle(1'b0, '0, 1'b1, header(MOD_ID, 4'd1, 3), 1'b0);
    @(posedge clk);
    #1;
    c_s_axis_tvalid = 1'b0;
    phv_valid_in    = 1'b0;
    note(ctrl_state === ST_WRITE, $sformatf("pre_reset ctrl_state act=%0d exp=%0d", ctrl_state, ST_WRITE));
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, rand_phv(3), 1'b0, '0, 1'b0);
    d = rand_dw();
    d[38:0] = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 2'b10, 3'd1, 16'h8000};
    cycle(1'b0, '0, 1'b1, header(MOD_ID, 4'd1, 3), 1'b0);
    cycle(1'b0, '0, 1'b1, d, 1'b1);
    cycle(1'b1, rand_phv(3), 1'b0, '0, 1'b0);

    // Randomized mixed traffic.
    for (int c = 0; c < 800; c++) begin
      if (pd_q.size() == 0 && $urandom_range(0, 3) == 0) make_packet($urandom_range(0, 4));
      cv = (pd_q.size() > 0) && ($urandom_range(0, 3) != 0);
      d  = '0;
      cl = 1'b0;
      if (cv) begin
        d  = pd_q.pop_front();
        cl = pl_q.pop_front();
      end
      pv = ($urandom_range(0, 9) < 7);
      cycle(pv, rand_phv($urandom_range(0, ENTRY_NUM-1)), cv, d, cl);
    end
    run_pending();
    idle(2);

    for (int i = 0; i < 20 && (exp_q.size() > 0 || ctl_q.size() > 0); i++) @(posedge clk);
    @(negedge clk);
    note(exp_q.size() == 0 && ctl_q.size() == 0,
         $sformatf("drain pending phv=%0d ctl=%0d exp=0", exp_q.size(), ctl_q.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
